imem_loader: RTL and testbench

- Writer side of the instruction-memory interface that the IF stage reads: accepts a byte stream (UART-RX or switch/KEY strobe) and writes 16-bit instruction words into instruction memory from address 0.
- Holds the pipeline (cpu_hold, ORed into the core reset by the top level) for the whole load.
- Reports a sticky done or error status on LEDs/HEX.

---
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader.sv | 179 +++++++++++++++++
 tb/tb_imem_loader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the image loader.
// Latency: n/a (wires only).
// Backpressure: none; the byte source strobes in_valid and the loader always accepts.
//   in_valid/in_byte   : byte strobe from UART-RX or the switch/KEY path
//   mem_we/addr/wdata  : one-cycle write into instruction memory
// master = byte source / memory side, slave = the loader itself.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    modport master (
        output in_valid, in_byte,
        input  mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_byte,
        output mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader writing 16-bit words into instruction memory from address 0.
// Latency: mem_we pulses one cycle after the strobe carrying a word's low byte.
// Backpressure: none; every strobe is consumed, and a write never collides with the next byte.
//   clk, rst           : core clock, async active-low reset
//   bus (slave)        : byte input + instruction-memory write port
//   cpu_hold           : keeps the pipeline in reset during a load and after a failed one
//   load_done/load_err : sticky status of the last frame
//   words_loaded       : words written in the current/last frame
module imem_loader #(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 50000000
) (
    input  logic            clk,
    input  logic            rst,
    imem_loader_if.slave    bus,
    output logic            cpu_hold,
    output logic            load_done,
    output logic            load_err,
    output logic [ADDR_W:0] words_loaded
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   WORD_ONE = (ADDR_W + 1)'(1);
    // COUNT of zero stands for a full memory image
    localparam logic [ADDR_W:0]   N_FULL   = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE, COUNT, DATA_HI, DATA_LO, CHECK, DONE, ERR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [7:0]        chk_q, chk_d;
    logic [7:0]        hi_q, hi_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              in_frame;
    logic [ADDR_W-1:0] count_trunc;
    logic [ADDR_W:0]   words_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            words_q     <= '0;
            n_q         <= '0;
            chk_q       <= '0;
            hi_q        <= '0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            words_q     <= words_d;
            n_q         <= n_d;
            chk_q       <= chk_d;
            hi_q        <= hi_d;
            tmo_q       <= tmo_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        words_d     = words_q;
        n_d         = n_q;
        chk_d       = chk_q;
        hi_d        = hi_q;
        tmo_d       = tmo_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hold_d      = hold_q;
        done_d      = done_q;
        err_d       = err_q;

        // Narrower memories keep only the low ADDR_W bits of COUNT
        count_trunc = ADDR_W'(bus.in_byte);
        words_inc   = words_q + WORD_ONE;
        in_frame    = (state_q == COUNT) || (state_q == DATA_HI) ||
                      (state_q == DATA_LO) || (state_q == CHECK);

        case (state_q)
            IDLE, DONE, ERR: begin
                if (bus.in_valid && (bus.in_byte == SYNC_BYTE)) begin
                    state_d = COUNT;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    words_d = '0;
                    addr_d  = '0;
                    chk_d   = '0;
                    tmo_d   = '0;
                end
            end
            COUNT: begin
                if (bus.in_valid) begin
                    n_d     = (count_trunc == '0) ? N_FULL : {1'b0, count_trunc};
                    state_d = DATA_HI;
                end
            end
            DATA_HI: begin
                if (bus.in_valid) begin
                    hi_d    = bus.in_byte;
                    chk_d   = chk_q ^ bus.in_byte;
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (bus.in_valid) begin
                    chk_d       = chk_q ^ bus.in_byte;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = {hi_q, bus.in_byte};
                    // Wrap of addr only happens on the final word of a full image
                    addr_d      = addr_q + ADDR_ONE;
                    words_d     = words_inc;
                    state_d     = (words_inc == n_q) ? CHECK : DATA_HI;
                end
            end
            CHECK: begin
                if (bus.in_valid) begin
                    if (bus.in_byte == chk_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Idle-gap watchdog inside a frame; already-written words stay in memory
        if (in_frame) begin
            if (bus.in_valid) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                tmo_d   = '0;
                state_d = ERR;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_ONE;
            end
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_hold      = hold_q;
    assign load_done     = done_q;
    assign load_err      = err_q;
    assign words_loaded  = words_q;
endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    localparam int AW   = 4;
    localparam int TMO  = 16;
    localparam int NMAX = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(AW)) bus ();
    logic          cpu_hold, load_done, load_err;
    logic [AW:0]   words_loaded;

    imem_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Frame-level reference model: the byte list plus what it should produce
    logic [7:0] fb[$];
    int         fn;
    bit         fgood;
    int         last_addr;
    int         last_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_byte  = b;
        @(posedge clk);
        #1;
    endtask

    // Derive N and checksum validity straight from the frame rules
    task automatic analyze();
        int c;
        logic [7:0] x;
        c  = int'(fb[1]) % NMAX;
        fn = (c == 0) ? NMAX : c;
        x  = 8'h00;
        for (int i = 2; i < 2 + 2 * fn; i++) x ^= fb[i];
        fgood = (fb[2 + 2 * fn] == x);
    endtask

    task automatic make_random(input logic [7:0] count, input bit good);
        int c;
        int n;
        logic [7:0] x;
        logic [7:0] d;
        fb.delete();
        fb.push_back(8'hA5);
        fb.push_back(count);
        c = int'(count) % NMAX;
        n = (c == 0) ? NMAX : c;
        x = 8'h00;
        for (int i = 0; i < 2 * n; i++) begin
            d = 8'($urandom);
            x ^= d;
            fb.push_back(d);
        end
        fb.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    endtask

    task automatic idle_chk(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 8'h00);
            chk("idle_we", bus.mem_we, 1'b0);
            chk("idle_addr_hold", bus.mem_addr, last_addr);
            chk("idle_wdata_hold", bus.mem_wdata, last_data);
        end
    endtask

    // Send the first nbytes of fb (all of it when nbytes < 0)
    task automatic send_frame(input int max_gap, input int nbytes);
        int lim;
        int w;
        analyze();
        lim = (nbytes < 0) ? fb.size() : nbytes;
        for (int i = 0; i < lim; i++) begin
            if (i > 0 && max_gap > 0) idle_chk($urandom_range(0, max_gap));
            step(1'b1, fb[i]);
            if (i == 0) begin
                chk("sync_hold", cpu_hold, 1'b1);
                chk("sync_clr_done", load_done, 1'b0);
                chk("sync_clr_err", load_err, 1'b0);
                chk("sync_clr_words", words_loaded, 0);
            end
            if (i >= 3 && i < 2 + 2 * fn && (i % 2) == 1) begin
                w = (i - 3) / 2;
                last_addr = w % NMAX;
                last_data = {fb[i-1], fb[i]};
                chk("wr_we", bus.mem_we, 1'b1);
                chk("wr_addr", bus.mem_addr, last_addr);
                chk("wr_data", bus.mem_wdata, last_data);
                chk("wr_words", words_loaded, w + 1);
            end else begin
                chk("no_we", bus.mem_we, 1'b0);
            end
            if (i < fb.size() - 1) chk("frame_hold", cpu_hold, 1'b1);
        end
        if (lim == fb.size()) begin
            chk("end_done", load_done, fgood);
            chk("end_err", load_err, !fgood);
            chk("end_hold", cpu_hold, !fgood);
            chk("end_words", words_loaded, fn);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hold"},  cpu_hold, 1'b0);
        chk({tag, "_done"},  load_done, 1'b0);
        chk({tag, "_err"},   load_err, 1'b0);
        chk({tag, "_words"}, words_loaded, 0);
        chk({tag, "_we"},    bus.mem_we, 1'b0);
        chk({tag, "_addr"},  bus.mem_addr, 0);
        chk({tag, "_wdata"}, bus.mem_wdata, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        last_addr    = 0;
        last_data    = 0;
        rst          = 1'b1;
        #3 rst = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 chk_all_zero("post_reset");

        // Directed good frame
        fb = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_frame(0, -1);
        chk("dir_good_done", load_done, 1'b1);
        idle_chk(2);

        // Same frame, wrong checksum
        fb = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        send_frame(0, -1);
        chk("dir_bad_err", load_err, 1'b1);
        idle_chk(3);
        chk("err_hold_sticky", cpu_hold, 1'b1);

        // Good frame recovers from ERR
        make_random(8'h03, 1'b1);
        send_frame(2, -1);

        // Noise in DONE is ignored
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        step(1'b1, 8'hA4);
        chk("noise_we", bus.mem_we, 1'b0);
        chk("noise_hold", cpu_hold, 1'b0);
        chk("noise_done", load_done, 1'b1);
        chk("noise_words", words_loaded, fn);

        // SYNC then stall mid-frame until the idle watchdog fires
        step(1'b1, 8'hA5);
        chk("to_sync_hold", cpu_hold, 1'b1);
        chk("to_sync_done", load_done, 1'b0);
        step(1'b1, 8'h01);
        step(1'b1, 8'h12);
        for (int k = 0; k < TMO - 1; k++) step(1'b0, 8'h00);
        chk("to_before_err", load_err, 1'b0);
        chk("to_before_we", bus.mem_we, 1'b0);
        step(1'b0, 8'h00);
        chk("to_err", load_err, 1'b1);
        chk("to_hold", cpu_hold, 1'b1);
        chk("to_done", load_done, 1'b0);
        chk("to_words", words_loaded, 0);
        idle_chk(2);

        // Random frames: full-image and truncated counts first, back-to-back
        for (int k = 0; k < 12; k++) begin
            logic [7:0] cnt;
            cnt = (k == 0) ? 8'h00 : (k == 1) ? 8'h10 : (k == 2) ? 8'h11 : 8'($urandom_range(0, 255));
            make_random(cnt, (k < 3) ? 1'b1 : ($urandom_range(0, 3) != 0));
            send_frame((k < 3) ? 0 : 4, -1);
            if (k == 0) chk("full_last_addr", bus.mem_addr, NMAX - 1);
        end

        // Reset asserted while the low byte of word 3 of 5 is on the bus
        make_random(8'h05, 1'b1);
        send_frame(0, 7);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_byte  = fb[7];
        #2 rst = 1'b0;
        #1 chk_all_zero("mid_rst");
        @(posedge clk);
        #1 chk("mid_rst_no_we", bus.mem_we, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        last_addr = 0;
        last_data = 0;
        step(1'b1, 8'h12);
        step(1'b1, 8'h34);
        step(1'b1, 8'h56);
        step(1'b1, 8'h78);
        step(1'b1, 8'h9A);
        chk_all_zero("after_rst_ignored");

        // Recovery after reset
        make_random(8'h04, 1'b1);
        send_frame(0, -1);
        step(1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
